// File: rtl/mips_io_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_io_pkg : shared types and defaults for the push-button I/O sequencer
// Revision    : 1.0
// ---------------------------------------------------------------------------
package mips_io_pkg;

  localparam int DATA_W_DEFAULT       = 32;
  localparam int DEBOUNCE_CNT_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } io_state_e;

endpackage : mips_io_pkg
`default_nettype wire

// File: rtl/enter_debouncer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// enter_debouncer : 2-flop synchronizer followed by a stable-count debouncer
// Revision        : 1.0
// ---------------------------------------------------------------------------
module enter_debouncer
  import mips_io_pkg::*;
#(
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic filtered
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CNT - 1);

  logic       sync1_q;
  logic       sync2_q;
  logic       filt_q;
  logic [7:0] cnt_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      // Any sample matching the current level restarts the stability count.
      if (sync2_q == filt_q) begin
        cnt_q <= 8'd0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync2_q;
        cnt_q  <= 8'd0;
      end else begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
  end

  assign filtered = filt_q;

endmodule : enter_debouncer
`default_nettype wire

// File: rtl/io_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// io_sequencer : stalls the CPU on IN until an operator press captures data
// Revision     : 1.0
// ---------------------------------------------------------------------------
module io_sequencer
  import mips_io_pkg::*;
#(
  parameter int DATA_W       = DATA_W_DEFAULT,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enter,
  input  logic              inctrl,
  input  logic              outctrl,
  input  logic [0:DATA_W-1] fromCPU,
  input  logic [0:DATA_W-1] externalIn,
  output logic [0:DATA_W-1] forCPU,
  output logic [0:DATA_W-1] externalOut,
  output logic              stall,
  output logic              waiting,
  output logic [7:0]        inCount
);

  io_state_e         state_q;
  logic              filtered;
  logic              filt_prev_q;
  logic              press;
  logic [0:DATA_W-1] forCPU_q;
  logic [0:DATA_W-1] externalOut_q;
  logic [7:0]        inCount_q;

  enter_debouncer #(
    .DEBOUNCE_CNT (DEBOUNCE_CNT)
  ) u_debouncer (
    .clock    (clock),
    .reset    (reset),
    .raw      (enter),
    .filtered (filtered)
  );

  // One-cycle press pulse; it is only consumed in WAIT_PRESS, so presses seen
  // in any other state are dropped rather than remembered.
  assign press = filtered & ~filt_prev_q;

  assign stall = (inctrl && (state_q == IDLE || state_q == WAIT_RELEASE)) ||
                 (state_q == WAIT_PRESS);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      filt_prev_q   <= 1'b0;
      forCPU_q      <= '0;
      externalOut_q <= '0;
      inCount_q     <= 8'd0;
    end else begin
      filt_prev_q <= filtered;
      if (outctrl && !inctrl && !stall) begin
        externalOut_q <= fromCPU;
      end
      case (state_q)
        IDLE: begin
          if (inctrl) state_q <= WAIT_PRESS;
        end
        WAIT_PRESS: begin
          if (press) begin
            state_q  <= CAPTURE;
            forCPU_q <= externalIn;
          end
        end
        CAPTURE: begin
          inCount_q <= inCount_q + 8'd1;
          state_q   <= filtered ? WAIT_RELEASE : IDLE;
        end
        WAIT_RELEASE: begin
          if (!filtered) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign forCPU      = forCPU_q;
  assign externalOut = externalOut_q;
  assign inCount     = inCount_q;
  assign waiting     = (state_q == WAIT_PRESS);

endmodule : io_sequencer
`default_nettype wire

// File: doc/io_sequencer.md
IO_SEQUENCER -- requirements
Module: io_sequencer

Interface
REQ-001 Parameter DATA_W, default 32: width of every data port, bit 0 is the MSB ([0:DATA_W-1]).
REQ-002 Parameter DEBOUNCE_CNT, default 4: consecutive stable synchronized samples required to change the filtered enter level; legal range 1..255.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 enter  input  1  raw push-button, asynchronous to clock, may bounce.
REQ-006 inctrl  input  1  control unit decodes an IN instruction this cycle.
REQ-007 outctrl  input  1  control unit decodes an OUT instruction this cycle.
REQ-008 fromCPU  input  DATA_W  value the CPU writes to the output port.
REQ-009 externalIn  input  DATA_W  external switch or data word.
REQ-010 forCPU  output  DATA_W  registered captured input word presented to the CPU.
REQ-011 externalOut  output  DATA_W  registered output word.
REQ-012 stall  output  1  holds the CPU PC and suppresses register and memory writes while high.
REQ-013 waiting  output  1  high in WAIT_PRESS; drives a "press enter" LED.
REQ-014 inCount  output  8  number of completed IN captures, modulo 256.

Function
REQ-015 enter SHALL pass through a 2-flop synchronizer, then a debouncer: filtered changes to the synchronized value only after DEBOUNCE_CNT consecutive equal samples differing from it.
REQ-016 A press SHALL be a 0->1 transition of filtered.
REQ-017 FSM states: IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE.
REQ-018 IDLE: inctrl=1 -> WAIT_PRESS; otherwise stay.
REQ-019 WAIT_PRESS: press -> CAPTURE and forCPU <= externalIn on the same edge; otherwise stay.
REQ-020 CAPTURE: lasts exactly one cycle; -> WAIT_RELEASE if filtered=1, else IDLE; inCount increments by 1 on this state's exit edge, wrapping 255->0.
REQ-021 WAIT_RELEASE: filtered=0 -> IDLE.
REQ-022 stall (combinational) = inctrl AND state in {IDLE, WAIT_RELEASE}, OR state = WAIT_PRESS; stall SHALL be 0 in CAPTURE so the CPU retires the IN instruction with forCPU valid.
REQ-023 A press occurring in IDLE or WAIT_RELEASE SHALL be discarded, not buffered.
REQ-024 Back-to-back IN instructions SHALL each require a separate release and press.
REQ-025 externalOut <= fromCPU on an edge where outctrl=1, inctrl=0 and stall=0; otherwise it holds.
REQ-026 If inctrl and outctrl are both 1, the instruction SHALL be treated as IN only, and externalOut SHALL be unchanged.
REQ-027 Latency: with enter held steadily high, filtered rises at sample edge 2+DEBOUNCE_CNT, the state is CAPTURE one edge later, and stall falls in that cycle.

Reset
REQ-028 On reset low, asynchronously: state=IDLE; forCPU, externalOut, inCount=0; synchronizer flops, filtered and the debounce counter=0; stall=inctrl (combinational).
REQ-029 Reset asserted mid-WAIT_PRESS or mid-CAPTURE SHALL abort the operation with no capture and no inCount change.
REQ-030 If enter is held high through reset release, the resulting filtered rise SHALL occur outside WAIT_PRESS and SHALL NOT count as a press.

Structure
REQ-031 Package mips_io_pkg SHALL hold the FSM state enum and the DATA_W and DEBOUNCE_CNT defaults.
REQ-032 The synchronizer plus debouncer SHALL be one sub-module, enter_debouncer (ports clock, reset, raw, filtered).
REQ-033 io_sequencer SHALL connect between controlUnit (inctrl/outctrl) and the CPU (stall, forCPU), replacing the direct I/O path.

Verification
REQ-034 inctrl=1 held, externalIn=32'hDEADBEEF, enter 0->1 held -> stall=1 and waiting=1 until CAPTURE at edge 7 after the first high sample (DEBOUNCE_CNT=4); forCPU=DEADBEEF, inCount=1.
REQ-035 In WAIT_PRESS, enter pulses high for 3 cycles then a 5-cycle bounce pattern -> no capture; stall stays 1, inCount unchanged.
REQ-036 outctrl=1 with fromCPU=32'h0000_00A5 and stall=0 -> externalOut=000000A5 next edge; a later cycle with inctrl=outctrl=1 -> externalOut unchanged.
REQ-037 Two consecutive IN instructions with enter kept high after the first capture -> second stalls in WAIT_RELEASE; release then press -> second capture; inCount=2.
REQ-038 Reset pulsed low mid-WAIT_PRESS -> state IDLE, all outputs 0 immediately; 256 captures from reset -> inCount wraps to 0.
